// File: rtl/column_window_gen_if.sv
// Column-in / window-out link between the column feeder, column_window_gen and the window consumer.
interface column_window_gen_if #(
    parameter int unsigned PIX_W = 5,
    parameter int unsigned COL_W = 7
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PIX_W-1:0]     pixel_in0;
    logic [PIX_W-1:0]     pixel_in1;
    logic [PIX_W-1:0]     pixel_in2;
    logic [PIX_W-1:0]     pixel_in3;
    logic [PIX_W-1:0]     pixel_in4;
    logic                 load_end;
    logic                 win_valid;
    logic                 win_ready;
    logic [9*PIX_W-1:0]   win_data;
    logic [1:0]           win_row;
    logic [COL_W-1:0]     win_col;
    logic                 frame_done;

    modport master (
        output in_valid, pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4, load_end, win_ready,
        input  in_ready, win_valid, win_data, win_row, win_col, frame_done
    );

    modport slave (
        input  in_valid, pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4, load_end, win_ready,
        output in_ready, win_valid, win_data, win_row, win_col, frame_done
    );
endinterface

// File: rtl/column_window_gen.sv
// Builds 3x3 windows from a stream of 5-row image columns using a 3-column sliding buffer.
// Each full column triple yields windows centred on rows 1, 2 and 3.
module column_window_gen #(
    parameter int unsigned PIX_W    = 5,
    parameter int unsigned MAX_COLS = 102,
    parameter int unsigned COL_W    = 7
) (
    input  logic                clk,
    input  logic                reset,
    column_window_gen_if.slave  bus
);
    localparam int unsigned ROWS  = 5;
    localparam int unsigned WIN_W = 9 * PIX_W;

    typedef enum logic [1:0] {LOAD, EMIT, DONE} state_e;
    typedef logic [ROWS-1:0][PIX_W-1:0] col_t;

    state_e            state_q, state_d;
    col_t              c0_q, c1_q, c2_q, c0_d, c1_d, c2_d;
    logic [1:0]        ncol_q, ncol_d;
    logic [COL_W-1:0]  colidx_q, colidx_d;
    logic              last_q, last_d;
    logic              win_valid_q, win_valid_d;
    logic [WIN_W-1:0]  win_data_q, win_data_d;
    logic [1:0]        win_row_q, win_row_d;
    logic [COL_W-1:0]  win_col_q, win_col_d;
    logic              frame_done_q, frame_done_d;
    logic              accept;
    col_t              new_col;

    // Rows r-1..r+1 of the three buffered columns, top row and leftmost column first.
    function automatic logic [WIN_W-1:0] pack_win(input col_t a, input col_t b, input col_t c,
                                                  input logic [1:0] r);
        logic [2:0] rm, rc, rp;
        rm = 3'(r) - 3'd1;
        rc = 3'(r);
        rp = 3'(r) + 3'd1;
        return {a[rm], b[rm], c[rm], a[rc], b[rc], c[rc], a[rp], b[rp], c[rp]};
    endfunction

    assign bus.in_ready   = (state_q == LOAD) && !reset;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_data   = win_data_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = frame_done_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign new_col = {bus.pixel_in4, bus.pixel_in3, bus.pixel_in2, bus.pixel_in1, bus.pixel_in0};

    always_comb begin
        state_d      = state_q;
        c0_d         = c0_q;
        c1_d         = c1_q;
        c2_d         = c2_q;
        ncol_d       = ncol_q;
        colidx_d     = colidx_q;
        last_d       = last_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_data_d   = win_data_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            LOAD: begin
                if (accept) begin
                    c0_d     = c1_q;
                    c1_d     = c2_q;
                    c2_d     = new_col;
                    ncol_d   = (ncol_q == 2'd3) ? 2'd3 : ncol_q + 2'd1;
                    colidx_d = colidx_q + COL_W'(1);
                    if (bus.load_end || (32'(colidx_d) == MAX_COLS)) begin
                        last_d = 1'b1;
                    end
                    // A completed triple is always emitted, even on the frame's last column.
                    if (ncol_d == 2'd3) begin
                        state_d   = EMIT;
                        win_row_d = 2'd1;
                        win_col_d = colidx_q - COL_W'(1);
                    end else if (last_d) begin
                        state_d = DONE;
                    end
                end
            end
            EMIT: begin
                if (bus.win_ready) begin
                    if (win_row_q != 2'd3) begin
                        win_row_d = win_row_q + 2'd1;
                    end else begin
                        state_d = last_q ? DONE : LOAD;
                    end
                end
            end
            DONE: begin
                state_d  = LOAD;
                ncol_d   = 2'd0;
                colidx_d = '0;
                last_d   = 1'b0;
            end
            default: state_d = LOAD;
        endcase

        win_valid_d  = (state_d == EMIT);
        frame_done_d = (state_d == DONE);
        if (state_d == EMIT) begin
            win_data_d = pack_win(c0_d, c1_d, c2_d, win_row_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            c0_q         <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            ncol_q       <= 2'd0;
            colidx_q     <= '0;
            last_q       <= 1'b0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            win_row_q    <= 2'd0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            c0_q         <= c0_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            ncol_q       <= ncol_d;
            colidx_q     <= colidx_d;
            last_q       <= last_d;
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule
